// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse SubBytes unit.
//   - aes_state_e : control states of the sequential InvSubBytes engine
//   - AES_WORDS, AES_WORD_W : 128-bit state carried as four 32-bit words
//   - SBOX_FWD / SBOX_INV : FIPS-197 forward and inverse S-box tables (index = input byte)
package aes_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StSub, StOut} aes_state_e;

  localparam int unsigned AES_WORDS  = 4;
  localparam int unsigned AES_WORD_W = 32;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
    8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
    8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
    8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
    8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
    8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
    8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
    8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
    8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
    8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
    8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
    8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e,
    8'h81, 8'hf3, 8'hd7, 8'hfb, 8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb, 8'h54, 8'h7b, 8'h94, 8'h32,
    8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49,
    8'h6d, 8'h8b, 8'hd1, 8'h25, 8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92, 8'h6c, 8'h70, 8'h48, 8'h50,
    8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05,
    8'hb8, 8'hb3, 8'h45, 8'h06, 8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b, 8'h3a, 8'h91, 8'h11, 8'h41,
    8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8,
    8'h1c, 8'h75, 8'hdf, 8'h6e, 8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b, 8'hfc, 8'h56, 8'h3e, 8'h4b,
    8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59,
    8'h27, 8'h80, 8'hec, 8'h5f, 8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef, 8'ha0, 8'he0, 8'h3b, 8'h4d,
    8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63,
    8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_fwd(logic [7:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [7:0] sbox_inv(logic [7:0] b);
    return SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_inv_sboxb.sv
// Single-byte combinational AES inverse S-box.
//   data_i : input byte
//   data_o : InvSubBytes(data_i)
module aes_inv_sboxb
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = sbox_inv(data_i);

endmodule

// File: rtl/aes_inv_subbyte_seq.sv
// Sequential InvSubBytes unit with 32-bit streaming I/O.
// Loads a 128-bit state as four words (word 0 = bits 127:96), substitutes NSBOX bytes per
// cycle, then streams the result as four words with out_last on the final one.
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid / in_ready / in_data  : input word handshake
//   out_valid / out_ready / out_data / out_last : output word handshake
//   busy                           : high while substituting or emitting
// All outputs decode registered state only; no input-to-output combinational path.
module aes_inv_subbyte_seq
  import aes_pkg::*;
#(
  parameter int unsigned NSBOX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_WORD_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_WORD_W-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  if ((NSBOX != 4) && (NSBOX != 16)) begin : gen_nsbox_illegal
    $fatal(1, "aes_inv_subbyte_seq: NSBOX must be 4 or 16");
  end

  localparam int unsigned SubCycles = 16 / NSBOX;
  localparam int unsigned SliceW    = 8 * NSBOX;
  localparam int unsigned SubCntW   = (SubCycles > 1) ? $clog2(SubCycles) : 1;
  localparam logic [SubCntW-1:0] SubLast  = SubCntW'(SubCycles - 1);
  localparam logic [1:0]         WordLast = 2'(AES_WORDS - 1);

  aes_state_e         state_q, state_d;
  logic [1:0]         wcnt_q, wcnt_d;
  logic [SubCntW-1:0] scnt_q, scnt_d;
  logic [127:0]       buf_q, buf_d;

  logic [6:0]         word_lsb;
  logic [6:0]         slice_lsb;
  logic [SliceW-1:0]  sub_in;
  logic [SliceW-1:0]  sub_out;

  // Word k lives at bits [127-32k -: 32], i.e. LSB = 32*(3-k).
  assign word_lsb  = {~wcnt_q, 5'b0};
  // Slice j covers [127-SliceW*j -: SliceW]; slices walk from the MSB end downwards.
  assign slice_lsb = 7'(128 - SliceW * (int'(scnt_q) + 1));
  assign sub_in    = buf_q[slice_lsb +: SliceW];

  for (genvar i = 0; i < NSBOX; i++) begin : gen_sbox
    aes_inv_sboxb u_sbox (
      .data_i (sub_in[8*i +: 8]),
      .data_o (sub_out[8*i +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        if (in_valid && in_ready) begin
          buf_d[word_lsb +: AES_WORD_W] = in_data;
          if (wcnt_q == WordLast) begin
            wcnt_d  = '0;
            state_d = StSub;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
      StSub: begin
        buf_d[slice_lsb +: SliceW] = sub_out;
        if (scnt_q == SubLast) begin
          scnt_d  = '0;
          state_d = StOut;
        end else begin
          scnt_d = scnt_q + SubCntW'(1);
        end
      end
      StOut: begin
        if (out_valid && out_ready) begin
          if (wcnt_q == WordLast) begin
            wcnt_d  = '0;
            state_d = StLoad;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      buf_q   <= buf_d;
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StOut);
  assign out_last  = out_valid && (wcnt_q == WordLast);
  assign busy      = (state_q == StSub) || (state_q == StOut);
  assign out_data  = out_valid ? buf_q[word_lsb +: AES_WORD_W] : '0;

endmodule

// File: tb/tb_aes_inv_subbyte_seq.sv
// Self-checking bench for aes_inv_subbyte_seq, NSBOX = 4 (index 0) and NSBOX = 16 (index 1).
// Expected values come from a GF(2^8) model of the inverse S-box (inverse affine map followed
// by multiplicative inversion), independent of the lookup table used by the design.
module tb_aes_inv_subbyte_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid    [2];
  logic [31:0] in_data     [2];
  logic        out_ready   [2];
  logic        in_ready_o  [2];
  logic        out_valid_o [2];
  logic [31:0] out_data_o  [2];
  logic        out_last_o  [2];
  logic        busy_o      [2];

  int n_chk = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int acc_w0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  aes_inv_subbyte_seq #(.NSBOX(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready_o[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid_o[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data_o[0]),
    .out_last  (out_last_o[0]),
    .busy      (busy_o[0])
  );

  aes_inv_subbyte_seq #(.NSBOX(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready_o[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid_o[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data_o[1]),
    .out_last  (out_last_o[1]),
    .busy      (busy_o[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^-1 in GF(2^8); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r  = 8'h01;
    logic [7:0] sq = a;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_inv_byte(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_inv_byte(b[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (all entered and left on a negedge) ----------------
  task automatic send_words(input int d, input logic [127:0] blk, input int n, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) begin
        in_valid[d] = 1'b0;
        repeat ($urandom_range(0, gap)) @(negedge clk);
      end
      in_valid[d] = 1'b1;
      in_data[d]  = blk[96-32*i +: 32];
      guard = 0;
      while (!in_ready_o[d] && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("in_accept", in_ready_o[d], 1'b1);
      if (i == 0) acc_w0 = edge_cnt + 1;
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    in_data[d]  = '0;
  endtask

  // mode 0: always ready, 1: hold each word 10 cycles, 2: random ready
  task automatic recv_block(input int d, input int mode, input string tag,
                            output logic [127:0] got);
    int k = 0;
    int guard = 0;
    int hold = 0;
    bit holding = 0;
    logic [31:0] h_data = '0;
    logic h_last = 1'b0;
    logic rdy;
    got = '0;
    while (k < 4 && guard < 300) begin
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (hold >= 10);
      else rdy = 1'($urandom_range(0, 1));
      out_ready[d] = rdy;
      if (out_valid_o[d]) begin
        if (holding) begin
          chk({tag, "/stable_data"}, out_data_o[d], h_data);
          chk({tag, "/stable_last"}, out_last_o[d], h_last);
        end
        if (rdy) begin
          got[96-32*k +: 32] = out_data_o[d];
          chk({tag, "/last"}, out_last_o[d], (k == 3));
          k++;
          holding = 0;
          hold = 0;
        end else begin
          if (!holding) begin
            h_data = out_data_o[d];
            h_last = out_last_o[d];
          end
          holding = 1;
          hold++;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready[d] = 1'b0;
    chk({tag, "/words"}, k, 4);
  endtask

  task automatic run_block(input int d, input logic [127:0] blk, input logic [127:0] exp,
                           input int mode, input int gap, input string tag);
    logic [127:0] got;
    int lat;
    send_words(d, blk, 4, gap);
    chk({tag, "/busy"}, busy_o[d], 1'b1);
    // Edges counted with the word-3 acceptance edge as edge 1.
    lat = 1;
    while (!out_valid_o[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/latency"}, lat, (d == 0) ? 5 : 2);
    recv_block(d, mode, tag, got);
    chk({tag, "/data"}, got, exp);
    chk({tag, "/valid_drop"}, out_valid_o[d], 1'b0);
    chk({tag, "/ready_back"}, in_ready_o[d], 1'b1);
  endtask

  initial begin
    logic [127:0] blk;
    int t0;
    int guard;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", in_ready_o[d], 1'b0);
      chk("rst_out_valid", out_valid_o[d], 1'b0);
      chk("rst_out_last", out_last_o[d], 1'b0);
      chk("rst_busy", busy_o[d], 1'b0);
      chk("rst_out_data", out_data_o[d], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_to_load", in_ready_o[0], 1'b1);

    for (int d = 0; d < 2; d++) begin
      run_block(d, {4{32'h63636363}}, 128'h0, 0, 0, "basic");
      run_block(d, 128'h637c777b_f26b6fc5_3001672b_fed7ab76,
                128'h00010203_04050607_08090a0b_0c0d0e0f, 0, 0, "order");
      run_block(d, 128'h0, {4{32'h52525252}}, 0, 0, "zeros");
      // InvSbox: 16->ff, ed->53, 09->40, 63->00
      run_block(d, {32'h16ed0963, {3{32'h63636363}}},
                {32'hff534000, 96'h0}, 0, 0, "boundary");
      // Every byte value once across 16 blocks.
      for (int b = 0; b < 16; b++) begin
        for (int j = 0; j < 16; j++) blk[120-8*j +: 8] = 8'(16 * b + j);
        run_block(d, blk, ref_block(blk), 0, 0, "sweep");
      end
      blk = rand_block();
      run_block(d, blk, ref_block(blk), 1, 0, "hold");
      blk = rand_block();
      run_block(d, blk, ref_block(blk), 2, 0, "toggle");
      blk = rand_block();
      run_block(d, blk, ref_block(blk), 0, 3, "in_gap");
      for (int r = 0; r < 6; r++) begin
        blk = rand_block();
        run_block(d, blk, ref_block(blk), 2, 2, "random");
      end
      // Back-to-back blocks: first-word acceptances 8 + 16/NSBOX edges apart.
      blk = rand_block();
      run_block(d, blk, ref_block(blk), 0, 0, "tput_a");
      t0 = acc_w0;
      blk = rand_block();
      run_block(d, blk, ref_block(blk), 0, 0, "tput_b");
      chk("throughput", acc_w0 - t0, (d == 0) ? 12 : 9);
    end

    // Reset after two input words: partial block discarded.
    send_words(0, rand_block(), 2, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready_o[0], 1'b0);
    chk("rst_mid_busy", busy_o[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_idle", in_ready_o[0], 1'b0);
    @(negedge clk);
    chk("rst_mid_load", in_ready_o[0], 1'b1);
    blk = rand_block();
    run_block(0, blk, ref_block(blk), 0, 0, "post_rst_load");

    // Reset while emitting: out_valid drops without a clock edge.
    blk = rand_block();
    send_words(1, blk, 4, 0);
    guard = 0;
    while (!out_valid_o[1] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("out_before_rst", out_valid_o[1], 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_out_valid_async", out_valid_o[1], 1'b0);
    chk("rst_out_data_async", out_data_o[1], 32'h0);
    chk("rst_out_busy_async", busy_o[1], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    blk = rand_block();
    run_block(1, blk, ref_block(blk), 2, 1, "post_rst_out");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
